// File: rtl/l2_backing_mem.sv
// Single-beat AXI-lite word memory with a fixed, parameterised response latency.
// Optional MEM_BOUNDS_CHK_EN: out-of-range accesses answer SLVERR instead of aliasing.
module l2_backing_mem #(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int MEM_WORDS        = 1024,
  parameter int LATENCY          = 2
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_mem_axi_awaddr,
  input  logic                        s_mem_axi_awvalid,
  output logic                        s_mem_axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0] s_mem_axi_wdata,
  input  logic                        s_mem_axi_wvalid,
  output logic                        s_mem_axi_wready,
  output logic [1:0]                  s_mem_axi_bresp,
  output logic                        s_mem_axi_bvalid,
  input  logic                        s_mem_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_mem_axi_araddr,
  input  logic                        s_mem_axi_arvalid,
  output logic                        s_mem_axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0] s_mem_axi_rdata,
  output logic [1:0]                  s_mem_axi_rresp,
  output logic                        s_mem_axi_rvalid,
  input  logic                        s_mem_axi_rready
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_WAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rstate_e;

  logic [C_AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  wstate_e                     wstate_q, wstate_d;
  logic                        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [C_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]            wcnt_q, wcnt_d;
  logic                        awready_q, awready_d, wready_q, wready_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic                        mem_we;

  rstate_e                     rstate_q, rstate_d;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CNT_W-1:0]            rcnt_q, rcnt_d;
  logic                        arready_q, arready_d;
  logic                        rvalid_q, rvalid_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic             aw_oor, ar_oor;
  logic             unused_addr_bits;

  assign aw_idx = awaddr_q[2 +: IDX_W];
  assign ar_idx = araddr_q[2 +: IDX_W];
  assign unused_addr_bits = ^{awaddr_q[1:0], araddr_q[1:0],
                              awaddr_q >> (IDX_W + 2), araddr_q >> (IDX_W + 2)};

`ifdef MEM_BOUNDS_CHK_EN
  assign aw_oor = (awaddr_q >> (IDX_W + 2)) != '0;
  assign ar_oor = (araddr_q >> (IDX_W + 2)) != '0;
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  always_comb begin
    wstate_d  = wstate_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wcnt_d    = wcnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (wstate_q)
      W_COLLECT: begin
        if (s_mem_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_mem_axi_awaddr;
        end
        if (s_mem_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_mem_axi_wdata;
        end
        if (aw_held_d && w_held_d) begin
          wstate_d = W_WAIT;
          wcnt_d   = CNT_LOAD;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          mem_we   = !aw_oor;
          bvalid_d = 1'b1;
          bresp_d  = aw_oor ? RESP_SLVERR : RESP_OKAY;
          wstate_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      W_RESP: begin
        if (s_mem_axi_bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_COLLECT;
        end
      end
      default: wstate_d = W_COLLECT;
    endcase
    // Readies follow the current state, so they re-open one edge after the B handshake.
    awready_d = (wstate_q == W_COLLECT) && (wstate_d == W_COLLECT) && !aw_held_d;
    wready_d  = (wstate_q == W_COLLECT) && (wstate_d == W_COLLECT) && !w_held_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (s_mem_axi_arvalid && arready_q) begin
          araddr_d = s_mem_axi_araddr;
          rcnt_d   = CNT_LOAD;
          rstate_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          // Sampled before the same-edge write lands, so a collision returns old data.
          rdata_d  = ar_oor ? C_AXI_DATA_WIDTH'(32'hDEADBEEF) : mem[ar_idx];
          rresp_d  = ar_oor ? RESP_SLVERR : RESP_OKAY;
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      R_RESP: begin
        if (s_mem_axi_rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    arready_d = (rstate_d == R_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wstate_q  <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      araddr_q  <= '0;
      rcnt_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      araddr_q  <= araddr_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (mem_we) mem[aw_idx] <= wdata_q;
  end

  assign s_mem_axi_awready = awready_q;
  assign s_mem_axi_wready  = wready_q;
  assign s_mem_axi_bvalid  = bvalid_q;
  assign s_mem_axi_bresp   = bresp_q;
  assign s_mem_axi_arready = arready_q;
  assign s_mem_axi_rvalid  = rvalid_q;
  assign s_mem_axi_rresp   = rresp_q;
  assign s_mem_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_l2_backing_mem.sv
// Directed testbench for l2_backing_mem (LATENCY = 2, MEM_WORDS = 1024).
module tb_l2_backing_mem;
  localparam int LAT = 2;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  l2_backing_mem #(
    .C_AXI_ADDR_WIDTH(32),
    .C_AXI_DATA_WIDTH(32),
    .MEM_WORDS(1024),
    .LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_mem_axi_awaddr(awaddr), .s_mem_axi_awvalid(awvalid), .s_mem_axi_awready(awready),
    .s_mem_axi_wdata(wdata), .s_mem_axi_wvalid(wvalid), .s_mem_axi_wready(wready),
    .s_mem_axi_bresp(bresp), .s_mem_axi_bvalid(bvalid), .s_mem_axi_bready(bready),
    .s_mem_axi_araddr(araddr), .s_mem_axi_arvalid(arvalid), .s_mem_axi_arready(arready),
    .s_mem_axi_rdata(rdata), .s_mem_axi_rresp(rresp), .s_mem_axi_rvalid(rvalid),
    .s_mem_axi_rready(rready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Returns right after the edge that completed the later of the AW/W handshakes.
  task automatic send_write(input logic [31:0] a, input logic [31:0] d);
    logic aw_done, w_done, aw_hs, w_hs;
    int k;
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; k = 0;
    while (!(aw_done && w_done) && k < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      k++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin wvalid = 1'b0;  w_done = 1'b1;  end
    end
    if (!(aw_done && w_done)) begin
      tests++; fails++;
      $display("FAIL write_handshake addr=%h: aw_done=%0b w_done=%0b, required both 1", a, aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic send_read(input logic [31:0] a);
    logic hs;
    int k;
    araddr = a; arvalid = 1'b1; k = 0; hs = 1'b0;
    while (!hs && k < 20) begin
      hs = arvalid && arready;
      tick();
      k++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      tests++; fails++;
      $display("FAIL read_handshake addr=%h: no AR handshake within 20 cycles", a);
    end
  endtask

  task automatic wait_bvalid(output int n);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
      fails++;
      $display("FAIL reset_values: got aw=%b w=%b ar=%b b=%b r=%b bresp=%b rresp=%b rdata=%h, required all 0",
               awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
    end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    tests++;
    if ({awready, wready, arready} !== 3'b000) begin
      fails++; $display("FAIL ready_before_edge: got %b, required 000", {awready, wready, arready});
    end
    tick();
    tests++;
    if ({awready, wready, arready} !== 3'b111) begin
      fails++; $display("FAIL ready_after_edge: got %b, required 111", {awready, wready, arready});
    end
  endtask

  task automatic test_same_cycle_write_read();
    int n;
    send_write(32'h10, 32'hCAFE0001);
    wait_bvalid(n);
    tests++;
    if (n !== LAT + 1 || bresp !== 2'b00) begin
      fails++; $display("FAIL t1_bvalid: edges=%0d bresp=%b, required %0d and 00", n, bresp, LAT + 1);
    end
    tick();
    tests++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      fails++; $display("FAIL t1_bhs: bvalid=%b awready=%b, required 0 0", bvalid, awready);
    end
    tick();
    tests++;
    if ({awready, wready} !== 2'b11) begin
      fails++; $display("FAIL t1_reopen: got %b, required 11", {awready, wready});
    end
    send_read(32'h10);
    wait_rvalid(n);
    tests++;
    if (n !== LAT + 1 || rdata !== 32'hCAFE0001 || rresp !== 2'b00) begin
      fails++; $display("FAIL t1_read: edges=%0d rdata=%h rresp=%b, required %0d CAFE0001 00", n, rdata, rresp, LAT + 1);
    end
    tick();
  endtask

  task automatic test_w_before_aw();
    int n;
    wdata = 32'h12345678; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tests++;
    if (wready !== 1'b0 || awready !== 1'b1) begin
      fails++; $display("FAIL t2_wcapture: wready=%b awready=%b, required 0 1", wready, awready);
    end
    repeat (3) tick();
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_bvalid(n);
    tests++;
    if (n !== LAT + 1 || bresp !== 2'b00) begin
      fails++; $display("FAIL t2_bvalid: edges=%0d bresp=%b, required %0d 00", n, bresp, LAT + 1);
    end
    tick(); tick();
    send_read(32'h20);
    wait_rvalid(n);
    tests++;
    if (rdata !== 32'h12345678 || rresp !== 2'b00) begin
      fails++; $display("FAIL t2_readback: rdata=%h rresp=%b, required 12345678 00", rdata, rresp);
    end
    tick();
  endtask

  task automatic test_rready_backpressure();
    int n;
    int bad;
    rready = 1'b0;
    send_read(32'h10);
    wait_rvalid(n);
    tests++;
    if (n !== LAT + 1) begin
      fails++; $display("FAIL t3_latency: edges=%0d, required %0d", n, LAT + 1);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== 32'hCAFE0001 || rresp !== 2'b00 || arready !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL t3_hold: %0d unstable cycles, required 0", bad);
    end
    rready = 1'b1;
    tick();
    tests++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      fails++; $display("FAIL t3_release: rvalid=%b arready=%b, required 0 1", rvalid, arready);
    end
  endtask

  task automatic test_read_write_collision();
    int n;
    send_write(32'h30, 32'h11111111);
    wait_bvalid(n);
    tick(); tick();
    araddr = 32'h30; arvalid = 1'b1;
    awaddr = 32'h30; awvalid = 1'b1;
    wdata = 32'hAAAA5555; wvalid = 1'b1;
    tests++;
    if ({arready, awready, wready} !== 3'b111) begin
      fails++; $display("FAIL t4_ready: got %b, required 111", {arready, awready, wready});
    end
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    wait_rvalid(n);
    tests++;
    if (n !== LAT + 1 || bvalid !== 1'b1 || rdata !== 32'h11111111) begin
      fails++; $display("FAIL t4_collide: edges=%0d bvalid=%b rdata=%h, required %0d 1 11111111", n, bvalid, rdata, LAT + 1);
    end
    tick(); tick();
    send_read(32'h30);
    wait_rvalid(n);
    tests++;
    if (rdata !== 32'hAAAA5555) begin
      fails++; $display("FAIL t4_second_read: rdata=%h, required AAAA5555", rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    int n;
    logic seen;
    send_write(32'h40, 32'h55550000);
    wait_bvalid(n);
    tick(); tick();
    send_write(32'h40, 32'h99999999);
    tick();
    aresetn = 1'b0;
    #1;
    tests++;
    if ({bvalid, awready, wready, arready} !== 4'b0000) begin
      fails++; $display("FAIL t5_in_reset: got %b, required 0000", {bvalid, awready, wready, arready});
    end
    tick(); tick();
    aresetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bvalid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL t5_no_bvalid: bvalid seen=%b, required 0", seen);
    end
    send_read(32'h40);
    wait_rvalid(n);
    tests++;
    if (rdata !== 32'h55550000) begin
      fails++; $display("FAIL t5_old_word: rdata=%h, required 55550000", rdata);
    end
    tick();
    send_write(32'h40, 32'h77777777);
    wait_bvalid(n);
    tests++;
    if (n !== LAT + 1 || bresp !== 2'b00) begin
      fails++; $display("FAIL t5_post_write: edges=%0d bresp=%b, required %0d 00", n, bresp, LAT + 1);
    end
    tick(); tick();
    send_read(32'h40);
    wait_rvalid(n);
    tests++;
    if (rdata !== 32'h77777777) begin
      fails++; $display("FAIL t5_post_read: rdata=%h, required 77777777", rdata);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    int n;
    logic [1:0]  exp_bresp;
    logic [31:0] exp_word0;
`ifdef MEM_BOUNDS_CHK_EN
    exp_bresp = 2'b10; exp_word0 = 32'h01234567;
`else
    exp_bresp = 2'b00; exp_word0 = 32'h0BADF00D;
`endif
    send_write(32'h0, 32'h01234567);
    wait_bvalid(n);
    tick(); tick();
    send_write(32'h1000, 32'h0BADF00D);
    wait_bvalid(n);
    tests++;
    if (n !== LAT + 1 || bresp !== exp_bresp) begin
      fails++; $display("FAIL t6_bresp: edges=%0d bresp=%b, required %0d %b", n, bresp, LAT + 1, exp_bresp);
    end
    tick(); tick();
    send_read(32'h0);
    wait_rvalid(n);
    tests++;
    if (rdata !== exp_word0 || rresp !== 2'b00) begin
      fails++; $display("FAIL t6_word0: rdata=%h rresp=%b, required %h 00", rdata, rresp, exp_word0);
    end
    tick();
`ifdef MEM_BOUNDS_CHK_EN
    send_read(32'h1000);
    wait_rvalid(n);
    tests++;
    if (n !== LAT + 1 || rdata !== 32'hDEADBEEF || rresp !== 2'b10) begin
      fails++; $display("FAIL t6_oor_read: edges=%0d rdata=%h rresp=%b, required %0d DEADBEEF 10", n, rdata, rresp, LAT + 1);
    end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_same_cycle_write_read();
    test_w_before_aw();
    test_rready_backpressure();
    test_read_write_collision();
    test_reset_mid_write();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_backing_mem.md
Name: l2_backing_mem

Overview:
- Single-beat AXI-lite slave word memory. It sits directly downstream of the L1 cache master port.
- It services the L1's line fills (reads) and dirty write-backs (writes) with a programmable fixed access latency.
- It acts as the next-level store for cache bring-up and for system integration.
- Read and write channels are independent. Each allows one outstanding transaction.

Parameters:
- C_AXI_ADDR_WIDTH, 32, address width.
- C_AXI_DATA_WIDTH, 32, data/word width.
- MEM_WORDS, 1024, number of words stored; must be a power of two. IDX_W = $clog2(MEM_WORDS).
- LATENCY, 2, extra cycles between request capture and response valid. Range 0..15.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_mem_axi_awaddr  in  C_AXI_ADDR_WIDTH  write address
- s_mem_axi_awvalid  in  1  write address valid
- s_mem_axi_awready  out  1  write address ready
- s_mem_axi_wdata  in  C_AXI_DATA_WIDTH  write data
- s_mem_axi_wvalid  in  1  write data valid
- s_mem_axi_wready  out  1  write data ready
- s_mem_axi_bresp  out  2  write response
- s_mem_axi_bvalid  out  1  write response valid
- s_mem_axi_bready  in  1  write response ready
- s_mem_axi_araddr  in  C_AXI_ADDR_WIDTH  read address
- s_mem_axi_arvalid  in  1  read address valid
- s_mem_axi_arready  out  1  read address ready
- s_mem_axi_rdata  out  C_AXI_DATA_WIDTH  read data
- s_mem_axi_rresp  out  2  read response
- s_mem_axi_rvalid  out  1  read data valid
- s_mem_axi_rready  in  1  read data ready

Behaviour:
- Clock and reset: clock aclk; reset aresetn, asynchronous, active-low.
- Reset values: all readies 0; bvalid 0; rvalid 0; bresp 2'b00; rresp 2'b00; rdata 0. All internal FSMs return to idle. The memory array is NOT cleared and keeps its contents across reset.
- Readies are registered. They rise on the first aclk edge after aresetn deasserts.
- Word index = addr[2 +: IDX_W]. addr[1:0] is ignored.
- Write FSM has three states: W_COLLECT, W_WAIT, W_RESP.
  - W_COLLECT: awready = 1 until AW is captured; wready = 1 until W is captured. AW and W may arrive in either order or in the same cycle. Each is held in its own register.
  - When both are held, go to W_WAIT and load the latency counter with LATENCY. Both readies drop.
  - W_WAIT: count down to 0. Then write the word, assert bvalid with bresp = OKAY, and go to W_RESP.
  - Timing: bvalid rises LATENCY+1 edges after the edge that completed the later of the AW/W handshakes.
  - W_RESP: hold bvalid and bresp stable until bready. On the handshake edge, go to W_COLLECT. The readies re-assert on the next edge.
- Read FSM has three states: R_IDLE, R_WAIT, R_RESP.
  - R_IDLE: arready = 1. On the AR handshake, capture the address, load the counter, and go to R_WAIT.
  - R_WAIT: count down to 0. Then sample the memory into rdata, assert rvalid with rresp = OKAY, and go to R_RESP.
  - Timing: rvalid rises LATENCY+1 edges after the AR handshake.
  - R_RESP: hold rdata, rresp and rvalid stable until rready. Then go to R_IDLE.
- Latency counter width = max(1, $clog2(LATENCY+1)). LATENCY = 0 gives a response on the edge after capture.
- Same-edge read sample and write commit to the same word: the read returns the pre-write data.
- bvalid and rvalid never depend combinationally on bready or rready.
- A reset asserted mid-transaction drops the pending request with no response. A write that had not yet committed is not stored.

Optional Feature:
- Macro: MEM_BOUNDS_CHK_EN.
- When defined: any address with addr[C_AXI_ADDR_WIDTH-1 : IDX_W+2] != 0 is out of range.
  - An out-of-range write is discarded and answered with bresp = 2'b10 (SLVERR).
  - An out-of-range read returns rresp = 2'b10 and rdata = 32'hDEADBEEF.
  - Latency is unchanged.
- When undefined: upper address bits are ignored. Addresses alias modulo MEM_WORDS and always respond OKAY.

Test Plan:
1. LATENCY = 2. AW 0x10 and W 0xCAFE0001 in the same cycle, bready held 1 -> bvalid rises 3 edges later with bresp = 00. Then AR 0x10 -> rvalid 3 edges after the AR handshake, rdata = 0xCAFE0001.
2. W 0x12345678 presented 4 cycles before AW 0x20 -> wready drops after the W capture. bvalid rises 3 edges after the AW handshake. A readback of 0x20 returns 0x12345678.
3. rready held 0 for 5 cycles after rvalid -> rdata, rresp and rvalid stay stable and arready stays 0. The first rready handshake returns the FSM to R_IDLE.
4. Read of 0x30 and write of 0x30 with 0xAAAA5555 issued on the same edge (old value 0x11111111) -> read returns 0x11111111. A second read returns 0xAAAA5555.
5. Pull aresetn low during W_WAIT, then release -> no bvalid is produced and the old word is unchanged. A write issued after reset completes normally.
6. With MEM_BOUNDS_CHK_EN and MEM_WORDS = 1024, write to 0x00001000 -> bresp = 10 and a read of 0x0 is unchanged. Without the macro -> the same write aliases to word 0, and a read of 0x0 returns the written data with OKAY.
